// File: rtl/signed_serial_multiplier_p_if.sv
// Serial operand/result bundle for signed_serial_multiplier_p.
// Carries ovf only when SMUL_OVF_FLAG_EN is defined.
interface signed_serial_multiplier_p_if #(
    parameter int unsigned WIDTH = 12
);
    logic                 x_in;
    logic                 sx;
    logic                 fx;
    logic                 y_in;
    logic                 sy;
    logic                 fy;
    logic                 mul;
    logic                 busy;
    logic                 done;
    logic                 sz;
    logic                 z_out;
    logic                 fz;
    logic [2*WIDTH-1:0]   z_par;
`ifdef SMUL_OVF_FLAG_EN
    logic                 ovf;

    modport slave (
        input  x_in, sx, y_in, sy, mul, sz,
        output fx, fy, busy, done, z_out, fz, z_par, ovf
    );

    modport master (
        output x_in, sx, y_in, sy, mul, sz,
        input  fx, fy, busy, done, z_out, fz, z_par, ovf
    );
`else
    modport slave (
        input  x_in, sx, y_in, sy, mul, sz,
        output fx, fy, busy, done, z_out, fz, z_par
    );

    modport master (
        output x_in, sx, y_in, sy, mul, sz,
        input  fx, fy, busy, done, z_out, fz, z_par
    );
`endif
endinterface

// File: rtl/signed_serial_multiplier_p.sv
// Serial-in/serial-out signed multiplier using sign-magnitude shift-add.
// Optional overflow flag (product not representable in WIDTH bits) under SMUL_OVF_FLAG_EN.
module signed_serial_multiplier_p #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = $clog2(2 * WIDTH) + 1
) (
    input logic                         clk,
    input logic                         rst,
    signed_serial_multiplier_p_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StAbs,
        StMult,
        StSign,
        StOut
    } state_e;

    state_e           state_q;

    // Operand shift-in registers and their fill counters.
    logic [WIDTH-1:0] x_reg_q;
    logic [WIDTH-1:0] y_reg_q;
    logic [CNT_W-1:0] x_cnt_q;
    logic [CNT_W-1:0] y_cnt_q;
    logic             fx_q;
    logic             fy_q;

    // Operands captured at start so the input registers can refill.
    logic [WIDTH-1:0] x_op_q;
    logic [WIDTH-1:0] y_op_q;
    logic             sign_q;

    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]    mcand_q;
    logic [PW-1:0]    acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic [PW-1:0]    z_sh_q;
    logic [PW-1:0]    z_par_q;
    logic             busy_q;
    logic             done_q;
    logic             fz_q;

    logic [WIDTH-1:0] x_mag;
    logic [WIDTH-1:0] y_mag;
    logic [PW-1:0]    res;
    logic             accept;

`ifdef SMUL_OVF_FLAG_EN
    logic             ovf_q;
    logic             ovf_n;
    logic [WIDTH:0]   res_top;
`endif

    always_comb begin
        accept = (state_q == StIdle) && fx_q && fy_q && bus.mul;
        // Negating the most negative value wraps back to itself, which read
        // as unsigned is exactly its magnitude.
        x_mag  = x_op_q[WIDTH-1] ? -x_op_q : x_op_q;
        y_mag  = y_op_q[WIDTH-1] ? -y_op_q : y_op_q;
        res    = sign_q ? -acc_q : acc_q;
    end

`ifdef SMUL_OVF_FLAG_EN
    // Representable in WIDTH bits iff the top WIDTH+1 bits are all equal.
    always_comb begin
        res_top = res[PW-1:WIDTH-1];
        ovf_n   = !((&res_top) || !(|res_top));
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            x_reg_q  <= '0;
            y_reg_q  <= '0;
            x_cnt_q  <= '0;
            y_cnt_q  <= '0;
            fx_q     <= 1'b0;
            fy_q     <= 1'b0;
            x_op_q   <= '0;
            y_op_q   <= '0;
            sign_q   <= 1'b0;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            z_sh_q   <= '0;
            z_par_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fz_q     <= 1'b0;
`ifdef SMUL_OVF_FLAG_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            fz_q <= 1'b0;

            if (accept) begin
                fx_q    <= 1'b0;
                x_cnt_q <= '0;
            end else if (!fx_q && bus.sx) begin
                x_reg_q <= {x_reg_q[WIDTH-2:0], bus.x_in};
                x_cnt_q <= x_cnt_q + CNT_W'(1);
                if (x_cnt_q == CNT_W'(WIDTH - 1)) begin
                    fx_q <= 1'b1;
                end
            end

            if (accept) begin
                fy_q    <= 1'b0;
                y_cnt_q <= '0;
            end else if (!fy_q && bus.sy) begin
                y_reg_q <= {y_reg_q[WIDTH-2:0], bus.y_in};
                y_cnt_q <= y_cnt_q + CNT_W'(1);
                if (y_cnt_q == CNT_W'(WIDTH - 1)) begin
                    fy_q <= 1'b1;
                end
            end

            case (state_q)
                StIdle: begin
                    if (accept) begin
                        x_op_q  <= x_reg_q;
                        y_op_q  <= y_reg_q;
                        sign_q  <= x_reg_q[WIDTH-1] ^ y_reg_q[WIDTH-1];
                        busy_q  <= 1'b1;
                        state_q <= StAbs;
                    end
                end

                StAbs: begin
                    mcand_q  <= {{WIDTH{1'b0}}, x_mag};
                    mplier_q <= y_mag;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    state_q  <= StMult;
                end

                StMult: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= StSign;
                    end
                end

                StSign: begin
                    z_sh_q  <= res;
                    z_par_q <= res;
`ifdef SMUL_OVF_FLAG_EN
                    ovf_q   <= ovf_n;
`endif
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StOut;
                end

                StOut: begin
                    if (bus.sz) begin
                        z_sh_q <= z_sh_q << 1;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(PW - 1)) begin
                            fz_q    <= 1'b1;
                            done_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // z_sh_q is fully shifted out by the time OUT is left, so z_out is 0 elsewhere.
    assign bus.fx    = fx_q;
    assign bus.fy    = fy_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.fz    = fz_q;
    assign bus.z_out = z_sh_q[PW-1];
    assign bus.z_par = z_par_q;
`ifdef SMUL_OVF_FLAG_EN
    assign bus.ovf   = ovf_q;
`endif

endmodule

// File: doc/signed_serial_multiplier_p.md
Name: signed_serial_multiplier_p

Overview:
- Parametrised serial-in/serial-out signed multiplier: two WIDTH-bit two's-complement operands shift in bit-serially, multiply via sign-magnitude shift-add, 2*WIDTH-bit signed product shifts out serially.
- Captures operands at start, so the next operand pair can load while a multiply runs.
- Sits between serial operand sources and a serial result sink in the arithmetic datapath.

Parameters:
- WIDTH, 12, operand width in bits (>=4); product width is 2*WIDTH.
- CNT_W, $clog2(2*WIDTH)+1, internal bit/iteration counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- x_in  in  1  serial X operand bit, MSB first.
- sx  in  1  shift-enable for x_in; one bit captured per cycle sx=1.
- fx  out  1  X register full (WIDTH bits captured).
- y_in  in  1  serial Y operand bit, MSB first.
- sy  in  1  shift-enable for y_in.
- fy  out  1  Y register full.
- mul  in  1  start request; sampled each cycle.
- busy  out  1  multiply in progress (ABS, MULT, SIGN states).
- done  out  1  product valid in output register; high until result fully drained.
- sz  in  1  shift-enable for the result.
- z_out  out  1  current result MSB (bit 2*WIDTH-1 of output shift register).
- fz  out  1  one-cycle pulse: final result bit consumed.
- z_par  out  2*WIDTH  parallel signed product; stable while done=1.

Behaviour:
- Reset (rst=1 at an edge): every register cleared. fx=fy=busy=done=fz=0, z_out=0, z_par=0, state IDLE. Reset mid-load, mid-multiply or mid-drain aborts with no residual state.
- Operand load: with fx=0 and sx=1, x_reg <= {x_reg[WIDTH-2:0], x_in}, x count +1. fx rises the cycle after the WIDTH-th bit. sx is ignored while fx=1. Y loads identically and independently via sy/fy.
- Start: mul accepted only when state=IDLE, fx=1 and fy=1; otherwise ignored (no queuing).
  - On accept: x_reg/y_reg are copied to internal operand registers, fx/fy and their counters are cleared, and the product sign is latched as x[MSB]^y[MSB].
  - Loading of new operands may begin the next cycle.
- State machine: IDLE -> ABS (1 cycle) -> MULT (WIDTH cycles) -> SIGN (1 cycle) -> OUT -> IDLE.
  - ABS: magnitudes formed; |-2^(WIDTH-1)| = 2^(WIDTH-1) is held as WIDTH-bit unsigned, exact.
  - MULT: one shift-add iteration per cycle, LSB of multiplier first; the accumulator is 2*WIDTH bits unsigned.
  - SIGN: if the sign is 1, result = two's-complement negation of the magnitude, else the magnitude. Negating zero yields 0.
  - The result is loaded into the output shift register and z_par, and done=1 from the first OUT cycle.
- Latency: mul sampled at edge N -> done=1 after edge N+WIDTH+2. busy=1 for exactly WIDTH+2 cycles.
- Drain: in OUT, each cycle sz=1 shifts the output register left by one and z_out presents the next bit.
  - After 2*WIDTH sz cycles, fz pulses for 1 cycle, done falls that same edge, and the state returns to IDLE.
  - sz outside OUT is ignored; z_out is then 0.
  - z_par holds its value until the next SIGN state.
- Simultaneous events:
  - mul with fx=1, fy=1 in the same cycle the final drain bit shifts: not accepted (state still OUT). Accepted the next cycle.
  - sx/sy during MULT are legal.
- Range: the full product range is representable; (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) is positive with no wrap.

Optional Feature:
- Macro SMUL_OVF_FLAG_EN.
- Defined: extra output port ovf (1 bit), registered in SIGN alongside z_par. ovf=1 iff the signed product is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1], i.e. not representable in WIDTH bits. Held with z_par; reset 0.
- Undefined: the port is absent and no overflow logic is built. All other behaviour is identical.

Test Plan:
- WIDTH=12: load X=5 (12'h005), Y=-3 (12'hFFD), pulse mul -> busy 14 cycles; done with z_par=24'hFFFFF1; 24 sz cycles stream 1111_1111_1111_1111_1111_0001; fz pulses after bit 24; ovf=0.
- X=-2048 (12'h800), Y=-2048 -> z_par=24'h400000 (+4194304); ovf=1.
- X=12'h7FF, Y=12'h7FF -> z_par=24'h3FF001; X=0, Y=-1 -> z_par=24'h000000 (negated zero stays 0).
- mul with only fx=1 -> ignored, busy stays 0. Then load Y and pulse mul -> accepted. Load the next X/Y during MULT -> fx/fy rise before done; second mul held off until fz, then accepted and gives the correct second product.
- rst asserted mid-MULT and separately mid-drain -> next cycle all outputs 0, state IDLE; a fresh 5 * -3 then completes with correct timing.
- Extra sx pulses after fx=1 and sz pulses while done=0 -> no effect on x_reg, z_out or counters.
